// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera I2C register-write sequencer.
// Holds the FSM state encoding, default device addresses and the address-byte helper.
package cam_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_GAP,
    ST_DEV,
    ST_REG,
    ST_HI,
    ST_LO,
    ST_RETRY_GAP
  } cam_state_e;

  localparam logic       I2C_WRITE_BIT     = 1'b0;
  localparam logic [6:0] DEFAULT_CAM0_ADDR = 7'h48;
  localparam logic [6:0] DEFAULT_CAM1_ADDR = 7'h5D;
  localparam int         TRIPLET_LEN       = 3;
  localparam int         TIMER_W           = 16;

  function automatic logic [7:0] dev_write_byte(input logic [6:0] addr);
    return {addr, I2C_WRITE_BIT};
  endfunction

endpackage

// File: rtl/cam_i2c_cycle_timer.sv
// Down-counter shared by the inter-transaction gap and the per-byte engine timeout.
// A load sets the count; it then decrements to zero and holds, flagging expiry.
module cam_i2c_cycle_timer
  import cam_cfg_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/cam_i2c_write_sequencer.sv
// Frames camera-config register triplets into I2C write transactions on the byte engine,
// with bounded NACK/timeout retry, an idle gap between attempts and sticky error report.
module cam_i2c_write_sequencer
  import cam_cfg_pkg::*;
#(
  parameter logic [6:0] CAM0_DEV_ADDR  = DEFAULT_CAM0_ADDR,
  parameter logic [6:0] CAM1_DEV_ADDR  = DEFAULT_CAM1_ADDR,
  parameter int         MAX_RETRY      = 2,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic        sysClk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_cam_id,
  output logic        in_ready,
  output logic [7:0]  eng_byte,
  output logic        eng_start,
  output logic        eng_stop,
  output logic        eng_valid,
  input  logic        eng_ready,
  input  logic        eng_done,
  input  logic        eng_ack_err,
  output logic        eng_bus_sel,
  output logic        busy,
  output logic        err,
  output logic [7:0]  err_reg_addr,
  input  logic        err_clr,
  output logic [15:0] txn_count,
  output cam_state_e  dbg_state
);

  // Both sides handshake valid/ready: a transfer happens on a rising sysClk edge where
  // valid and ready are both high; valid and its payload never change until that edge.

  cam_state_e         state;
  logic [1:0]         idx;
  logic [2:0]         retry_cnt;
  logic [7:0]         reg_addr;
  logic [7:0]         data_hi;
  logic [7:0]         data_lo;

  logic               send_state;
  logic               byte_accept;
  logic               wait_done;
  logic               fail_now;
  logic               last_byte_in;
  logic               eng_accept;
  logic               timer_load;
  logic               timer_expired;
  logic [TIMER_W-1:0] timer_value;

  assign send_state   = (state == ST_DEV) || (state == ST_REG) ||
                        (state == ST_HI)  || (state == ST_LO);
  assign byte_accept  = in_valid && in_ready;
  assign last_byte_in = (state == ST_COLLECT) && byte_accept && (idx == 2'(TRIPLET_LEN - 1));
  assign eng_accept   = send_state && eng_valid && eng_ready;
  // eng_valid low inside a send state means the byte is on the bus and we await eng_done.
  assign wait_done    = send_state && !eng_valid;
  assign fail_now     = wait_done && (eng_done ? eng_ack_err : timer_expired);
  assign timer_load   = last_byte_in || fail_now || eng_accept;
  assign timer_value  = eng_accept ? TIMER_W'(TIMEOUT_CYCLES - 1) : TIMER_W'(GAP_CYCLES - 1);

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  cam_i2c_cycle_timer #(.W(TIMER_W)) u_timer (
    .clk        (sysClk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  always_ff @(posedge sysClk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      retry_cnt    <= '0;
      reg_addr     <= '0;
      data_hi      <= '0;
      data_lo      <= '0;
      in_ready     <= 1'b0;
      eng_byte     <= '0;
      eng_start    <= 1'b0;
      eng_stop     <= 1'b0;
      eng_valid    <= 1'b0;
      eng_bus_sel  <= 1'b0;
      err          <= 1'b0;
      err_reg_addr <= '0;
      txn_count    <= '0;
    end else begin
      // Clear first so a same-cycle drop below re-sets the flag.
      if (err_clr) err <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (byte_accept) begin
            reg_addr    <= in_byte;
            eng_bus_sel <= in_cam_id;
            idx         <= 2'd1;
            state       <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (last_byte_in) begin
            data_lo  <= in_byte;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_GAP;
          end else if (byte_accept) begin
            data_hi <= in_byte;
            idx     <= idx + 2'd1;
          end
        end
        ST_GAP, ST_RETRY_GAP: begin
          if (timer_expired) begin
            if (state == ST_RETRY_GAP) retry_cnt <= retry_cnt + 3'd1;
            eng_byte  <= dev_write_byte(eng_bus_sel ? CAM1_DEV_ADDR : CAM0_DEV_ADDR);
            eng_start <= 1'b1;
            eng_stop  <= 1'b0;
            eng_valid <= 1'b1;
            state     <= ST_DEV;
          end
        end
        ST_DEV, ST_REG, ST_HI, ST_LO: begin
          if (eng_valid) begin
            if (eng_ready) eng_valid <= 1'b0;
          end else if (fail_now) begin
            eng_start <= 1'b0;
            eng_stop  <= 1'b0;
            if (retry_cnt < 3'(MAX_RETRY)) begin
              state <= ST_RETRY_GAP;
            end else begin
              err          <= 1'b1;
              err_reg_addr <= reg_addr;
              retry_cnt    <= '0;
              in_ready     <= 1'b1;
              state        <= ST_IDLE;
            end
          end else if (eng_done) begin
            eng_start <= 1'b0;
            case (state)
              ST_DEV: begin
                eng_byte  <= reg_addr;
                eng_valid <= 1'b1;
                state     <= ST_REG;
              end
              ST_REG: begin
                eng_byte  <= data_hi;
                eng_valid <= 1'b1;
                state     <= ST_HI;
              end
              ST_HI: begin
                eng_byte  <= data_lo;
                eng_stop  <= 1'b1;
                eng_valid <= 1'b1;
                state     <= ST_LO;
              end
              default: begin
                eng_stop  <= 1'b0;
                txn_count <= txn_count + 16'd1;
                retry_cnt <= '0;
                in_ready  <= 1'b1;
                state     <= ST_IDLE;
              end
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_i2c_write_sequencer.sv
// Directed bench for the camera I2C write sequencer: a behavioural byte engine logs every
// accepted byte, and each scenario task compares that log and the status outputs to hand values.
module tb_cam_i2c_write_sequencer;
  import cam_cfg_pkg::*;

  localparam int GAP     = 16;
  localparam int TIMEOUT = 4096;

  logic        sysClk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_cam_id;
  logic        in_ready;
  logic [7:0]  eng_byte;
  logic        eng_start;
  logic        eng_stop;
  logic        eng_valid;
  logic        eng_ready;
  logic        eng_done = 1'b0;
  logic        eng_ack_err = 1'b0;
  logic        eng_bus_sel;
  logic        busy;
  logic        err;
  logic [7:0]  err_reg_addr;
  logic        err_clr;
  logic [15:0] txn_count;
  cam_state_e  dbg_state;

  cam_i2c_write_sequencer #(
    .CAM0_DEV_ADDR (7'h48),
    .CAM1_DEV_ADDR (7'h5D),
    .MAX_RETRY     (2),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .sysClk      (sysClk),
    .rst         (rst),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_cam_id   (in_cam_id),
    .in_ready    (in_ready),
    .eng_byte    (eng_byte),
    .eng_start   (eng_start),
    .eng_stop    (eng_stop),
    .eng_valid   (eng_valid),
    .eng_ready   (eng_ready),
    .eng_done    (eng_done),
    .eng_ack_err (eng_ack_err),
    .eng_bus_sel (eng_bus_sel),
    .busy        (busy),
    .err         (err),
    .err_reg_addr(err_reg_addr),
    .err_clr     (err_clr),
    .txn_count   (txn_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 sysClk = ~sysClk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge sysClk) cyc = cyc + 1;

  // ---------------- engine model and scoreboard ----------------
  // log entry = {bus_sel, start, stop, byte}
  logic [10:0] log_q[$];
  int          log_cyc[$];
  logic [10:0] exp_q[$];
  int          nack_idx   = -1;
  int          nack_upto  = 0;
  bit          never_done = 1'b0;
  int          attempt    = 0;
  int          cur_idx    = 0;
  bit          pend       = 1'b0;
  int          nack_cyc   = 0;

  always @(negedge sysClk or posedge rst) begin
    if (rst) begin
      pend        = 1'b0;
      eng_done    = 1'b0;
      eng_ack_err = 1'b0;
    end else begin
      eng_done    = 1'b0;
      eng_ack_err = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (!never_done) begin
          eng_done    = 1'b1;
          eng_ack_err = (cur_idx == nack_idx) && (attempt <= nack_upto);
          if (eng_ack_err) nack_cyc = cyc;
        end
      end
      if (eng_valid && eng_ready) begin
        if (eng_start) begin
          attempt = attempt + 1;
          cur_idx = 0;
        end else begin
          cur_idx = cur_idx + 1;
        end
        log_q.push_back({eng_bus_sel, eng_start, eng_stop, eng_byte});
        log_cyc.push_back(cyc);
        pend = 1'b1;
      end
    end
  end

  function automatic logic [10:0] ent(input logic sel, input logic s, input logic p,
                                      input logic [7:0] b);
    return {sel, s, p, b};
  endfunction

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic push_byte(input logic cam, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    in_byte   = b;
    in_cam_id = cam;
    in_valid  = 1'b1;
    while (!in_ready && n < 20000) begin
      @(negedge sysClk);
      n++;
    end
    acc = cyc;
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL push_accept: byte %h never accepted, in_ready=%b required 1", b, in_ready);
    end
    @(posedge sysClk);
    @(negedge sysClk);
    in_valid  = 1'b0;
    in_cam_id = 1'b0;
  endtask

  task automatic push_triplet(input logic cam, input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, output int acc);
    int t;
    push_byte(cam, a, t);
    push_byte(cam, h, t);
    push_byte(cam, l, acc);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge sysClk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_cam_id = 1'b0; err_clr = 1'b0; eng_ready = 1'b1;
    repeat (3) @(negedge sysClk);
    checks++;
    if ({in_ready, eng_valid, eng_start, eng_stop, busy, err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {in_ready, eng_valid, eng_start, eng_stop, busy, err});
    end
    checks++;
    if ({txn_count, err_reg_addr, eng_byte, eng_bus_sel} !== 33'b0) begin
      failures++;
      $display("FAIL reset_values: txn=%h err_addr=%h byte=%h sel=%b required 0",
               txn_count, err_reg_addr, eng_byte, eng_bus_sel);
    end
    rst = 1'b0;
    @(negedge sysClk);
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b state=%0d required 1/IDLE", in_ready, dbg_state);
    end
  endtask

  task automatic test_single;
    int base, acc;
    base = log_q.size();
    push_triplet(1'b0, 8'h09, 8'h01, 8'hF4, acc);
    wait_idle(500);
    exp_q = {};
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h90));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h09));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h01));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 8'hF4));
    checks++;
    if (log_q.size() - base !== 4) begin
      failures++;
      $display("FAIL single_count: got %0d bytes required 4", log_q.size() - base);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL single_byte%0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (log_q.size() > base && log_cyc[base] - acc !== GAP + 1) begin
      failures++;
      $display("FAIL single_latency: got %0d cycles required %0d", log_cyc[base] - acc, GAP + 1);
    end
    checks++;
    if (txn_count !== 16'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL single_status: txn=%0d err=%b required 1/0", txn_count, err);
    end
  endtask

  task automatic test_cam1_stall;
    int base, acc, n;
    base = log_q.size();
    eng_ready = 1'b0;
    push_triplet(1'b1, 8'h0D, 8'h00, 8'h01, acc);
    n = 0;
    while (!eng_valid && n < 100) begin
      @(negedge sysClk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({eng_valid, eng_start, eng_stop, eng_bus_sel, eng_byte} !== {4'b1101, 8'hBA}) begin
        failures++;
        $display("FAIL cam1_hold%0d: got v=%b s=%b p=%b sel=%b byte=%h required 1 1 0 1 ba",
                 i, eng_valid, eng_start, eng_stop, eng_bus_sel, eng_byte);
      end
      @(negedge sysClk);
    end
    @(posedge sysClk);
    #1 eng_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge sysClk);
      n++;
      checks++;
      if (eng_bus_sel !== 1'b1) begin
        failures++;
        $display("FAIL cam1_bus_sel: got %b required 1 mid-transaction", eng_bus_sel);
      end
    end
    wait_idle(10);
    exp_q = {};
    exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 8'hBA));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 8'h0D));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 8'h00));
    exp_q.push_back(ent(1'b1, 1'b0, 1'b1, 8'h01));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL cam1_byte%0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (txn_count !== 16'd2) begin
      failures++;
      $display("FAIL cam1_txn: got %0d required 2", txn_count);
    end
  endtask

  task automatic test_nack_exhaust;
    int base, acc;
    base      = log_q.size();
    nack_idx  = 1;
    nack_upto = attempt + 3;
    push_triplet(1'b1, 8'h0D, 8'h00, 8'h01, acc);
    wait_idle(1000);
    nack_idx = -1;
    exp_q = {};
    for (int a = 0; a < 3; a++) begin
      exp_q.push_back(ent(1'b1, 1'b1, 1'b0, 8'hBA));
      exp_q.push_back(ent(1'b1, 1'b0, 1'b0, 8'h0D));
    end
    checks++;
    if (log_q.size() - base !== 6) begin
      failures++;
      $display("FAIL nack3_count: got %0d bytes required 6", log_q.size() - base);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL nack3_byte%0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (err !== 1'b1 || err_reg_addr !== 8'h0D || txn_count !== 16'd2 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL nack3_status: err=%b addr=%h txn=%0d state=%0d required 1/0d/2/IDLE",
               err, err_reg_addr, txn_count, dbg_state);
    end
    err_clr = 1'b1;
    @(negedge sysClk);
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0 || err_reg_addr !== 8'h0D) begin
      failures++;
      $display("FAIL err_clr: err=%b addr=%h required 0/0d", err, err_reg_addr);
    end
  endtask

  task automatic test_nack_once;
    int base, acc;
    base      = log_q.size();
    nack_idx  = 1;
    nack_upto = attempt + 1;
    push_triplet(1'b0, 8'h2A, 8'h55, 8'hAA, acc);
    wait_idle(1000);
    nack_idx = -1;
    exp_q = {};
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h90));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h2A));
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h90));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h2A));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h55));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 8'hAA));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL nack1_byte%0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (log_q.size() > base + 2 && log_cyc[base + 2] - nack_cyc !== GAP + 1) begin
      failures++;
      $display("FAIL nack1_gap: got %0d cycles required %0d", log_cyc[base + 2] - nack_cyc, GAP + 1);
    end
    checks++;
    if (err !== 1'b0 || txn_count !== 16'd3) begin
      failures++;
      $display("FAIL nack1_status: err=%b txn=%0d required 0/3", err, txn_count);
    end
  endtask

  task automatic test_timeout;
    int base, acc;
    base       = log_q.size();
    never_done = 1'b1;
    push_triplet(1'b0, 8'h30, 8'h11, 8'h22, acc);
    wait_idle(20000);
    never_done = 1'b0;
    checks++;
    if (log_q.size() - base !== 3) begin
      failures++;
      $display("FAIL timeout_count: got %0d bytes required 3", log_q.size() - base);
    end
    for (int i = 0; i < 3; i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== ent(1'b0, 1'b1, 1'b0, 8'h90)) begin
        failures++;
        $display("FAIL timeout_byte%0d: got %h required 290", i, got);
      end
    end
    checks++;
    if (log_q.size() > base + 1 && log_cyc[base + 1] - log_cyc[base] !== TIMEOUT + GAP + 1) begin
      failures++;
      $display("FAIL timeout_interval: got %0d cycles required %0d",
               log_cyc[base + 1] - log_cyc[base], TIMEOUT + GAP + 1);
    end
    checks++;
    if (err !== 1'b1 || err_reg_addr !== 8'h30 || txn_count !== 16'd3) begin
      failures++;
      $display("FAIL timeout_status: err=%b addr=%h txn=%0d required 1/30/3", err, err_reg_addr, txn_count);
    end
    err_clr = 1'b1;
    @(negedge sysClk);
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [7:0] tr [7][3];
    int base, acc;
    tr = '{'{8'h40, 8'hA0, 8'h0F}, '{8'h41, 8'hA1, 8'h0E}, '{8'h42, 8'hA2, 8'h0D},
           '{8'h43, 8'hA3, 8'h0C}, '{8'h44, 8'hA4, 8'h0B}, '{8'h45, 8'hA5, 8'h0A},
           '{8'h46, 8'hA6, 8'h09}};
    base = log_q.size();
    exp_q = {};
    for (int t = 0; t < 7; t++) begin
      logic sel;
      sel = (t % 2 == 1);
      push_triplet(sel, tr[t][0], tr[t][1], tr[t][2], acc);
      exp_q.push_back(ent(sel, 1'b1, 1'b0, sel ? 8'hBA : 8'h90));
      exp_q.push_back(ent(sel, 1'b0, 1'b0, tr[t][0]));
      exp_q.push_back(ent(sel, 1'b0, 1'b0, tr[t][1]));
      exp_q.push_back(ent(sel, 1'b0, 1'b1, tr[t][2]));
    end
    wait_idle(1000);
    checks++;
    if (log_q.size() - base !== 28) begin
      failures++;
      $display("FAIL b2b_count: got %0d bytes required 28", log_q.size() - base);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (txn_count !== 16'd10 || err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_status: txn=%0d err=%b required 10/0", txn_count, err);
    end
  endtask

  task automatic test_reset_mid;
    int base, acc, n;
    push_triplet(1'b1, 8'h55, 8'h66, 8'h77, acc);
    n = 0;
    while (dbg_state !== ST_HI && n < 500) begin
      @(negedge sysClk);
      n++;
    end
    checks++;
    if (dbg_state !== ST_HI) begin
      failures++;
      $display("FAIL rstmid_reach_hi: state=%0d required HI", dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, eng_valid, eng_start, eng_stop, busy, err, eng_bus_sel} !== 7'b0 ||
        eng_byte !== 8'h00 || txn_count !== 16'd0 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rstmid_async: flags=%b byte=%h txn=%0d state=%0d required 0/00/0/IDLE",
               {in_ready, eng_valid, eng_start, eng_stop, busy, err, eng_bus_sel},
               eng_byte, txn_count, dbg_state);
    end
    @(negedge sysClk);
    @(negedge sysClk);
    rst = 1'b0;
    @(negedge sysClk);
    base = log_q.size();
    push_triplet(1'b0, 8'h21, 8'h43, 8'h65, acc);
    wait_idle(500);
    exp_q = {};
    exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'h90));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h21));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b0, 8'h43));
    exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 8'h65));
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [10:0] got;
      got = (base + i < log_q.size()) ? log_q[base + i] : 11'bx;
      checks++;
      if (got !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_byte%0d: got %h required %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (txn_count !== 16'd1) begin
      failures++;
      $display("FAIL rstmid_txn: got %0d required 1", txn_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_single;
    test_cam1_stall;
    test_nack_exhaust;
    test_nack_once;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
